// File: rtl/phy_pkg.sv
// phy_pkg: constants and receive-FSM state encoding shared by the PHY lane
// serializer and deserializer.
package phy_pkg;
   localparam logic [7:0] COM_BYTE = 8'hBC;
   localparam int unsigned COM_LOCK_DEFAULT = 4;
   typedef enum logic [1:0] {
      SEARCH   = 2'd0,
      ALIGNING = 2'd1,
      LOCKED   = 2'd2
   } rx_state_e;
endpackage

// File: rtl/serial_paralelo.sv
// serial_paralelo: MSB-first deserializer that aligns on the COM symbol, locks
// after COM_LOCK consecutive COMs and presents each non-COM byte for one byte period.
module serial_paralelo #(
   parameter logic [7:0] COM_BYTE = phy_pkg::COM_BYTE,
   parameter int unsigned COM_LOCK = phy_pkg::COM_LOCK_DEFAULT
) (
   input  logic       clk_32f,
   input  logic       reset,
   input  logic       data_in,
   output logic [7:0] data_out,
   output logic       valid_out,
   output logic       active,
   output logic       byte_strobe
);
   logic [7:0] sr_q, sr_d, data_q, data_d, incoming;
   logic [2:0] bit_q, bit_d;
   logic [3:0] com_q, com_d, com_inc;
   logic valid_q, valid_d, active_q, active_d, strobe_q, strobe_d, is_com, boundary;
   phy_pkg::rx_state_e state_q, state_d;
   assign incoming = {sr_q[6:0], data_in};
   assign is_com = incoming == COM_BYTE;
   assign boundary = bit_q == 3'd7;
   assign com_inc = com_q + 4'd1;
   assign data_out = data_q;
   assign valid_out = valid_q;
   assign active = active_q;
   assign byte_strobe = strobe_q;
   always_ff @(posedge clk_32f)
      if (reset) begin
         sr_q <= '0;
         bit_q <= '0;
         com_q <= '0;
         data_q <= '0;
         valid_q <= 1'b0;
         active_q <= 1'b0;
         strobe_q <= 1'b0;
         state_q <= phy_pkg::SEARCH;
      end else begin
         sr_q <= sr_d;
         bit_q <= bit_d;
         com_q <= com_d;
         data_q <= data_d;
         valid_q <= valid_d;
         active_q <= active_d;
         strobe_q <= strobe_d;
         state_q <= state_d;
      end
   // SEARCH compares every bit position; once a COM is found bit_q counts byte phase.
   always_comb begin
      sr_d = incoming;
      bit_d = bit_q + 3'd1;
      com_d = com_q;
      data_d = data_q;
      valid_d = valid_q;
      active_d = active_q;
      strobe_d = 1'b0;
      state_d = state_q;
      case (state_q)
         phy_pkg::SEARCH:
            if (is_com) begin
               bit_d = '0;
               com_d = 4'd1;
               state_d = (COM_LOCK == 1) ? phy_pkg::LOCKED : phy_pkg::ALIGNING;
               active_d = COM_LOCK == 1;
            end
         phy_pkg::ALIGNING:
            if (boundary) begin
               strobe_d = 1'b1;
               if (is_com) begin
                  com_d = com_inc;
                  if (com_inc == 4'(COM_LOCK)) begin
                     state_d = phy_pkg::LOCKED;
                     active_d = 1'b1;
                  end
               end else begin
                  com_d = '0;
                  state_d = phy_pkg::SEARCH;
               end
            end
         phy_pkg::LOCKED:
            if (boundary) begin
               strobe_d = 1'b1;
               valid_d = !is_com;
               data_d = is_com ? data_q : incoming;
            end
         default: state_d = phy_pkg::SEARCH;
      endcase
   end
endmodule

// File: tb/tb_serial_paralelo.sv
// tb_serial_paralelo: directed checks of alignment, lock, data delivery and reset
// for the default lock count and for a single-COM lock instance.
module tb_serial_paralelo;
   logic clk_32f = 1'b0, reset = 1'b1, data_in = 1'b0;
   logic [7:0] d0, d1;
   logic v0, a0, s0, v1, a1, s1;
   int tests = 0, fails = 0;
   typedef struct {
      logic [7:0] din;
      logic [7:0] dout;
      logic valid, active, strobe;
   } vec_t;
   vec_t vecs[8];
   logic [7:0] pd;
   logic pv, pa;

   serial_paralelo u0 (.clk_32f(clk_32f), .reset(reset), .data_in(data_in),
      .data_out(d0), .valid_out(v0), .active(a0), .byte_strobe(s0));
   serial_paralelo #(.COM_LOCK(1)) u1 (.clk_32f(clk_32f), .reset(reset), .data_in(data_in),
      .data_out(d1), .valid_out(v1), .active(a1), .byte_strobe(s1));

   always #5 clk_32f = ~clk_32f;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic [7:0] d, input logic v, input logic a,
                            input logic s, input logic [7:0] ed, input logic ev, input logic ea,
                            input logic es);
      chk({tag, " data_out"}, d, ed);
      chk({tag, " valid_out"}, {7'b0, v}, {7'b0, ev});
      chk({tag, " active"}, {7'b0, a}, {7'b0, ea});
      chk({tag, " byte_strobe"}, {7'b0, s}, {7'b0, es});
   endtask

   task automatic send_bit(input logic b);
      data_in = b;
      @(posedge clk_32f);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      send_bit(1'b0);
      reset = 1'b0;
   endtask

   initial begin
      vecs[0] = '{8'hBC, 8'h00, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{8'hBC, 8'h00, 1'b0, 1'b0, 1'b1};
      vecs[2] = '{8'hBC, 8'h00, 1'b0, 1'b0, 1'b1};
      vecs[3] = '{8'hBC, 8'h00, 1'b0, 1'b1, 1'b1};
      vecs[4] = '{8'hA5, 8'hA5, 1'b1, 1'b1, 1'b1};
      vecs[5] = '{8'h3C, 8'h3C, 1'b1, 1'b1, 1'b1};
      vecs[6] = '{8'hBC, 8'h3C, 1'b0, 1'b1, 1'b1};
      vecs[7] = '{8'h01, 8'h01, 1'b1, 1'b1, 1'b1};
      send_bit(1'b1);
      send_bit(1'b0);
      check_out("reset u0", d0, v0, a0, s0, 8'h00, 1'b0, 1'b0, 1'b0);
      check_out("reset u1", d1, v1, a1, s1, 8'h00, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      // Outputs must hold the previous byte's values on every non-boundary bit.
      pd = 8'h00; pv = 1'b0; pa = 1'b0;
      for (int k = 0; k < 8; k++) begin
         for (int i = 7; i >= 1; i--) begin
            send_bit(vecs[k].din[i]);
            check_out($sformatf("vec%0d bit%0d", k, 7 - i), d0, v0, a0, s0, pd, pv, pa, 1'b0);
         end
         send_bit(vecs[k].din[0]);
         check_out($sformatf("vec%0d end", k), d0, v0, a0, s0,
                   vecs[k].dout, vecs[k].valid, vecs[k].active, vecs[k].strobe);
         pd = vecs[k].dout; pv = vecs[k].valid; pa = vecs[k].active;
      end
      do_reset();
      for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)));
      for (int n = 1; n <= 4; n++) begin
         send_byte(8'hBC);
         check_out($sformatf("offset com%0d", n), d0, v0, a0, s0, 8'h00, 1'b0, n == 4, n > 1);
      end
      send_byte(8'h5A);
      check_out("offset data", d0, v0, a0, s0, 8'h5A, 1'b1, 1'b1, 1'b1);
      do_reset();
      send_byte(8'hBC);
      send_byte(8'hBC);
      check_out("abort com2", d0, v0, a0, s0, 8'h00, 1'b0, 1'b0, 1'b1);
      send_byte(8'h55);
      check_out("abort 55", d0, v0, a0, s0, 8'h00, 1'b0, 1'b0, 1'b1);
      for (int n = 1; n <= 4; n++) begin
         send_byte(8'hBC);
         check_out($sformatf("relock com%0d", n), d0, v0, a0, s0, 8'h00, 1'b0, n == 4, n > 1);
      end
      send_byte(8'hA5);
      check_out("relock A5", d0, v0, a0, s0, 8'hA5, 1'b1, 1'b1, 1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b1);
      reset = 1'b1;
      send_bit(1'b1);
      reset = 1'b0;
      check_out("midbyte reset", d0, v0, a0, s0, 8'h00, 1'b0, 1'b0, 1'b0);
      for (int n = 1; n <= 4; n++) begin
         send_byte(8'hBC);
         check_out($sformatf("post-reset com%0d", n), d0, v0, a0, s0, 8'h00, 1'b0, n == 4, n > 1);
      end
      send_byte(8'hC3);
      check_out("post-reset C3", d0, v0, a0, s0, 8'hC3, 1'b1, 1'b1, 1'b1);
      do_reset();
      send_byte(8'hBC);
      check_out("lock1 com", d1, v1, a1, s1, 8'h00, 1'b0, 1'b1, 1'b0);
      check_out("lock4 com", d0, v0, a0, s0, 8'h00, 1'b0, 1'b0, 1'b0);
      send_byte(8'h7E);
      check_out("lock1 7E", d1, v1, a1, s1, 8'h7E, 1'b1, 1'b1, 1'b1);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/serial_paralelo.md
Name: serial_paralelo

Overview:
Receive-side deserializer of the PHY lane, directly downstream of the transmit serializer. It takes the 1-bit MSB-first stream at clk_32f and aligns to the COM symbol 8'hBC, which the serializer sends while its valid is low. After a run of consecutive COMs it declares the lane active. It then delivers each non-COM byte on an 8-bit bus with a valid flag, held for one byte period (8 clk_32f cycles).

Parameters:
COM_BYTE, 8'hBC, alignment/idle symbol; matches the serializer's idle pattern.
COM_LOCK, 4, consecutive COM bytes (including the first detected) required to assert active; legal range 1..15.

Ports:
clk_32f  input  1  bit clock; every bit sampled on posedge.
reset  input  1  synchronous, active-high; clock clk_32f.
data_in  input  1  serial bit, MSB of each byte first.
data_out  output  8  last received non-COM byte.
valid_out  output  1  high while data_out holds a byte received in the current byte period.
active  output  1  lane aligned and locked.
byte_strobe  output  1  one-cycle pulse on each byte boundary once aligned (ALIGNING or LOCKED).

Behaviour:
- Reset (sampled high on posedge): data_out=8'h00, valid_out=0, active=0, byte_strobe=0, shift register=0, bit_cnt=0, com_cnt=0, state=SEARCH. Reset mid-byte discards the partial byte. Reset has priority over all other events.
- Shift register sr[7:0]: every cycle sr <= {sr[6:0], data_in}. "Incoming byte" means {sr[6:0], data_in}, evaluated combinationally in the same cycle.
- bit_cnt[2:0] is a wrapping counter, 7 -> 0. A byte boundary is a cycle where bit_cnt==7.
- State SEARCH:
  - Each cycle, compare the incoming byte to COM_BYTE.
  - On match: bit_cnt <= 0, com_cnt <= 1. If COM_LOCK==1, go to LOCKED with active <= 1; otherwise go to ALIGNING.
  - bit_cnt is don't-care in SEARCH.
- State ALIGNING:
  - Check only at byte boundaries.
  - Incoming byte == COM: com_cnt++. When com_cnt+1 == COM_LOCK, go to LOCKED with active <= 1 (same edge).
  - Incoming byte != COM: go to SEARCH, com_cnt <= 0. Searching resumes on the next bit; no retro-scan.
  - byte_strobe pulses at each boundary. valid_out stays 0.
- State LOCKED, at each byte boundary:
  - byte_strobe <= 1.
  - Incoming byte == COM: valid_out <= 0, data_out unchanged.
  - Otherwise: data_out <= incoming byte, valid_out <= 1.
  - Outputs are held until the next boundary. byte_strobe is 0 on all other cycles.
- Latency: last bit of a byte sampled on edge t; data_out/valid_out/active/byte_strobe change on edge t (registered) and are visible after t. So data_out is valid 8 bit-times after the byte's first bit was sampled.
- Lock persists until reset. Data bytes equal to 8'hBC are indistinguishable from idle (a protocol restriction on the serializer side).
- com_cnt is 4 bits and saturates at COM_LOCK; it does not wrap.
- If data_in contains X/Z, behaviour is undefined; the bench drives only 0/1.

Decomposition:
- Shared package phy_pkg: COM_BYTE constant (also used by the serializer), state enum SEARCH/ALIGNING/LOCKED (2-bit), and the COM_LOCK default.
- No sub-module. Shift register, counters and FSM are one always block plus a small combinational compare. Estimated 120-160 lines.

Test Plan:
- Reset release, then 4×8'hBC MSB-first (1,0,1,1,1,1,0,0 repeated), no preceding garbage -> byte_strobe pulses at bits 16, 24, 32; active rises on the edge sampling bit 32; valid_out=0 throughout.
- After lock, send 8'hA5, 8'h3C, 8'hBC, 8'h01 -> data_out=A5 with valid_out=1 for 8 cycles, then 3C/1, then 3C held with valid_out=0, then 01/1.
- 3 random bits, then 4×BC -> alignment at the first BC whose last bit completes the match; active after the 4th BC; the bit offset is absorbed.
- 2×BC, then 8'h55, then 4×BC -> active stays 0 through 8'h55 (back to SEARCH); active asserts only after the final 4 COMs.
- Reset asserted for 1 cycle mid-byte while LOCKED with data_out=A5 -> next edge: data_out=00, valid_out=0, active=0; 4 new COMs are needed to relock.
- COM_LOCK=1 override: a single BC -> active on the edge completing that BC; the following byte 8'h7E -> data_out=7E, valid_out=1.
